// File: rtl/dmr_stream_join.sv
// dmr_stream_join: joins NUM_IN redundant stream copies into one checked, registered stream.
// Define DMR_STREAM_JOIN_MISMATCH_CNT_EN to enable the saturating mismatch counter.
module dmr_stream_join #(
    parameter type         T        = logic,
    parameter int unsigned NUM_IN   = 2,
    parameter int unsigned MAX_SKEW = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_IN-1:0] valid_i,
    output logic [NUM_IN-1:0] ready_o,
    input  T     [NUM_IN-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output T                  data_o,
    output logic              error_o,
    output logic              repeat_o,
    output logic [CNT_W-1:0]  mismatch_cnt_o
);
    localparam int unsigned SW = $clog2(MAX_SKEW + 1);

    logic          all_v, any_v, eq, out_free, accept, mism, skew, timeout;
    logic          valid_d, valid_q, error_d, error_q;
    T              data_d, data_q;
    logic [SW-1:0] skew_d, skew_q;

    always_comb begin
        all_v = &valid_i;
        any_v = |valid_i;
        eq = 1'b1;
        for (int k = 1; k < NUM_IN; k++) eq = eq & (data_i[k] == data_i[0]);
        out_free = !valid_q | ready_i;
        accept = all_v & eq & out_free;
        mism = all_v & !eq;
        skew = any_v & !all_v;
        timeout = skew && (skew_q == SW'(MAX_SKEW - 1));
        // A timeout drops only the copies that showed up, so the skewed beat is flushed.
        ready_o = rst_i ? '0 : (accept | mism) ? '1 : timeout ? valid_i : '0;
        skew_d = (skew && !timeout) ? skew_q + SW'(1) : '0;
        valid_d = accept ? 1'b1 : ready_i ? 1'b0 : valid_q;
        data_d = accept ? data_i[0] : data_q;
        error_d = mism | timeout;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            error_q <= 1'b0;
            skew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            error_q <= error_d;
            skew_q  <= skew_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign error_o  = error_q;
    assign repeat_o = error_q;

`ifdef DMR_STREAM_JOIN_MISMATCH_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb cnt_d = (error_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign mismatch_cnt_o = cnt_q;
`else
    assign mismatch_cnt_o = '0;
`endif
endmodule
